// File: rtl/button_debounce_pulse.sv
// Push-button conditioner: two-flop synchronizer, polarity normalization and a
// four-state debounce FSM producing a clean level plus press/release one-shots.
//
// state        | meaning
// -------------+---------------------------------------------------------
// IDLE         | stable released; counter held at 0
// PRESS_WAIT   | press seen, counting stable pressed samples
// PRESSED      | stable pressed; Button_Level = 1
// RELEASE_WAIT | release seen, counting stable released samples
module button_debounce_pulse #(
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int ACTIVE_LOW_BUTTON = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic Button_In,
    output logic Button_Level,
    output logic One_Shot,
    output logic Release_Pulse
);

    localparam int            CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Raw level of a released button; also the XOR mask that normalizes to 1 = pressed.
    localparam logic          RAW_RELEASED = (ACTIVE_LOW_BUTTON != 0);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [1:0]       sync_q;
    logic             sync_pressed;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             one_shot_q;
    logic             release_q;

    // Synchronizer resets to the released level so reset release never looks like a press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= {2{RAW_RELEASED}};
        end else begin
            sync_q <= {sync_q[0], Button_In};
        end
    end

    assign sync_pressed = sync_q[1] ^ RAW_RELEASED;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            level_q    <= 1'b0;
            one_shot_q <= 1'b0;
            release_q  <= 1'b0;
        end else begin
            one_shot_q <= 1'b0;
            release_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (sync_pressed) begin
                        state_q <= PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync_pressed) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q    <= PRESSED;
                        cnt_q      <= '0;
                        level_q    <= 1'b1;
                        one_shot_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    cnt_q <= '0;
                    if (!sync_pressed) begin
                        state_q <= RELEASE_WAIT;
                    end
                end
                RELEASE_WAIT: begin
                    // A bounce back to pressed keeps the level high and emits nothing.
                    if (sync_pressed) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign Button_Level  = level_q;
    assign One_Shot      = one_shot_q;
    assign Release_Pulse = release_q;

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Bench for button_debounce_pulse: an active-low and an active-high instance,
// directed latency/corner sequences, a vector table and a random run against a run-length model.
module tb_button_debounce_pulse;

    localparam int D = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic btn_l = 1'b1;
    logic btn_h = 1'b0;
    logic lvl_l, os_l, rp_l;
    logic lvl_h, os_h, rp_h;

    int checks = 0;
    int errors = 0;

    button_debounce_pulse #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW_BUTTON(1)) dut_l (
        .clk(clk), .reset(reset), .Button_In(btn_l),
        .Button_Level(lvl_l), .One_Shot(os_l), .Release_Pulse(rp_l)
    );

    button_debounce_pulse #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW_BUTTON(0)) dut_h (
        .clk(clk), .reset(reset), .Button_In(btn_h),
        .Button_Level(lvl_h), .One_Shot(os_h), .Release_Pulse(rp_h)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Watch 20 edges; edge 1 is the first edge after the call.
    task automatic measure(input bit rel, output int first_l, output int first_h,
                           output int cnt_l, output int cnt_h);
        first_l = -1; first_h = -1; cnt_l = 0; cnt_h = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (rel ? rp_l : os_l) begin cnt_l++; if (first_l < 0) first_l = n; end
            if (rel ? rp_h : os_h) begin cnt_h++; if (first_h < 0) first_h = n; end
        end
    endtask

    // Reference model: the level flips once the synchronized pressed value has
    // disagreed with it on D+1 consecutive edges; any agreement restarts the run.
    bit m_s1, m_s2, m_lvl, m_os, m_rp;
    int m_run;

    function automatic void model_reset();
        m_s1 = 0; m_s2 = 0; m_lvl = 0; m_os = 0; m_rp = 0; m_run = 0;
    endfunction

    function automatic void model_edge(input bit pressed);
        bit seen;
        seen = m_s2;
        m_s2 = m_s1;
        m_s1 = pressed;
        m_os = 0;
        m_rp = 0;
        if (seen != m_lvl) m_run++;
        else               m_run = 0;
        if (m_run == D + 1) begin
            m_lvl = !m_lvl;
            if (m_lvl) m_os = 1;
            else       m_rp = 1;
            m_run = 0;
        end
    endfunction

    typedef struct {
        bit btn;
        bit lvl;
        bit os;
        bit rp;
    } vec_t;

    vec_t tbl[36];

    initial begin
        int fl, fh, cl, ch;
        int hold_left;
        bit cur;

        // Clean press/release then a 3-cycle bounce, starting from idle at entry 0.
        for (int i = 0; i < 36; i++) begin
            tbl[i].btn = (i < 12) ? 1'b0 : (i < 24) ? 1'b1 : (i < 27) ? 1'b0 : 1'b1;
            tbl[i].lvl = (i >= 6 && i < 18);
            tbl[i].os  = (i == 6);
            tbl[i].rp  = (i == 18);
        end

        // Reset held with button pressed: everything low.
        btn_l = 1'b0; btn_h = 1'b1;
        repeat (2) tick();
        chk("rst_lvl_l", lvl_l, 0); chk("rst_os_l", os_l, 0); chk("rst_rp_l", rp_l, 0);
        chk("rst_lvl_h", lvl_h, 0); chk("rst_os_h", os_h, 0); chk("rst_rp_h", rp_h, 0);

        reset = 1'b1;
        measure(1'b0, fl, fh, cl, ch);
        chk("rst_rel_first_os_l", fl, 7); chk("rst_rel_cnt_os_l", cl, 1);
        chk("rst_rel_first_os_h", fh, 7); chk("rst_rel_cnt_os_h", ch, 1);

        // Long hold: no auto-repeat.
        cl = 0; ch = 0;
        for (int n = 0; n < 100; n++) begin
            tick();
            cl += int'(os_l) + int'(rp_l);
            ch += int'(os_h) + int'(rp_h);
        end
        chk("hold_no_repeat_l", cl, 0); chk("hold_no_repeat_h", ch, 0);
        chk("hold_lvl_l", lvl_l, 1);    chk("hold_lvl_h", lvl_h, 1);

        btn_l = 1'b1; btn_h = 1'b0;
        measure(1'b1, fl, fh, cl, ch);
        chk("release_first_rp_l", fl, 7); chk("release_cnt_rp_l", cl, 1);
        chk("release_first_rp_h", fh, 7); chk("release_cnt_rp_h", ch, 1);
        chk("release_lvl_l", lvl_l, 0);   chk("release_lvl_h", lvl_h, 0);

        for (int i = 0; i < 36; i++) begin
            btn_l = tbl[i].btn;
            btn_h = !tbl[i].btn;
            tick();
            chk($sformatf("vec%0d_lvl_l", i), lvl_l, tbl[i].lvl);
            chk($sformatf("vec%0d_os_l", i),  os_l,  tbl[i].os);
            chk($sformatf("vec%0d_rp_l", i),  rp_l,  tbl[i].rp);
            chk($sformatf("vec%0d_lvl_h", i), lvl_h, tbl[i].lvl);
            chk($sformatf("vec%0d_os_h", i),  os_h,  tbl[i].os);
            chk($sformatf("vec%0d_rp_h", i),  rp_h,  tbl[i].rp);
        end

        // Reset during the second cycle of PRESS_WAIT, button still held.
        btn_l = 1'b0; btn_h = 1'b1;
        repeat (4) tick();
        reset = 1'b0;
        #1;
        chk("midrst_os_l", os_l, 0); chk("midrst_lvl_l", lvl_l, 0);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("midrst_hold_os_l", os_l, 0);
            chk("midrst_hold_os_h", os_h, 0);
            chk("midrst_hold_lvl_l", lvl_l, 0);
        end
        reset = 1'b1;
        measure(1'b0, fl, fh, cl, ch);
        chk("midrst_first_os_l", fl, 7); chk("midrst_cnt_os_l", cl, 1);
        chk("midrst_first_os_h", fh, 7); chk("midrst_cnt_os_h", ch, 1);

        btn_l = 1'b1; btn_h = 1'b0;
        repeat (20) tick();

        // Polarity: only the active-high instance sees a press.
        btn_h = 1'b1;
        measure(1'b0, fl, fh, cl, ch);
        chk("pol_first_os_h", fh, 7); chk("pol_cnt_os_h", ch, 1);
        chk("pol_cnt_os_l", cl, 0);   chk("pol_lvl_l", lvl_l, 0);
        btn_h = 1'b0;
        repeat (20) tick();

        // Random bursts with occasional resets, against the model.
        reset = 1'b0;
        model_reset();
        tick();
        reset = 1'b1;
        hold_left = 0;
        cur = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b0;
                model_reset();
                #1;
                chk("rand_rst_lvl_l", lvl_l, 0); chk("rand_rst_os_l", os_l, 0);
                chk("rand_rst_rp_l", rp_l, 0);
                tick();
                reset = 1'b1;
            end
            if (hold_left == 0) begin
                cur = 1'($urandom_range(0, 1));
                hold_left = $urandom_range(1, 7);
            end
            hold_left--;
            btn_l = cur;
            btn_h = !cur;
            tick();
            model_edge(!cur);
            chk("rand_lvl_l", lvl_l, m_lvl); chk("rand_os_l", os_l, m_os); chk("rand_rp_l", rp_l, m_rp);
            chk("rand_lvl_h", lvl_h, m_lvl); chk("rand_os_h", os_h, m_os); chk("rand_rp_h", rp_h, m_rp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
